// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and muldiv_sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            illegal_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, kill_i,
        input  ready_o, busy_o, done_o, result_o, illegal_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, kill_i,
        output ready_o, busy_o, done_o, result_o, illegal_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: 32-step shift-add multiply / restoring divide on magnitudes.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divide ops finish as illegal.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);

    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
        return -x;
    endfunction

    function automatic logic [W2-1:0] f_neg2(input logic [W2-1:0] x);
        return -x;
    endfunction

    state_t          r_state;
    logic [5:0]      r_cnt;
    logic [2:0]      r_f3;
    logic            r_neg_q;
    logic            r_pend;
    logic            r_done;
    logic            r_illegal;
    logic [XLEN-1:0] r_result;
    logic [W2-1:0]   r_acc;
    logic [XLEN-1:0] r_opb;

    logic            w_accept, w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_special;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_spec_val, w_result_fix;
    logic [XLEN:0]   w_mul_sum;
    logic [W2-1:0]   w_mul_next, w_prod, w_step_next;

    assign w_accept = bus.valid_i && (r_state == S_IDLE);
    assign w_is_div = bus.funct3_i[2];
    // MULHSU treats only rs1 as signed; the U-variants treat both as unsigned.
    assign w_sgn_a  = w_is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    assign w_sgn_b  = w_is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
    assign w_neg_a  = w_sgn_a & bus.rs1_i[XLEN-1];
    assign w_neg_b  = w_sgn_b & bus.rs2_i[XLEN-1];
    assign w_mag_a  = w_neg_a ? f_neg(bus.rs1_i) : bus.rs1_i;
    assign w_mag_b  = w_neg_b ? f_neg(bus.rs2_i) : bus.rs2_i;

    // Accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[W2-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod     = r_neg_q ? f_neg2(r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
    logic            r_neg_r;
    logic [XLEN:0]   w_div_sh, w_div_diff;
    logic [W2-1:0]   w_div_next;
    logic            w_div_zero, w_ovf;

    // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_div_sh   = {r_acc[W2-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_next = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    assign w_div_zero = (bus.rs2_i == '0);
    assign w_ovf      = ~bus.funct3_i[0] && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2_i);
    assign w_special  = w_is_div & (w_div_zero | w_ovf);
    assign w_spec_val = w_div_zero ? (bus.funct3_i[1] ? bus.rs1_i : '1)
                                   : (bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    assign w_step_next = r_f3[2] ? w_div_next : w_mul_next;

    always_comb begin
        w_result_fix = w_prod[W2-1:XLEN];
        if (r_f3 == 3'b000)
            w_result_fix = w_prod[XLEN-1:0];
        else if (r_f3[2] && !r_f3[1])
            w_result_fix = r_neg_q ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        else if (r_f3[2])
            w_result_fix = r_neg_r ? f_neg(r_acc[W2-1:XLEN]) : r_acc[W2-1:XLEN];
    end
`else
    assign w_special   = w_is_div;
    assign w_spec_val  = '0;
    assign w_step_next = w_mul_next;

    always_comb begin
        w_result_fix = w_prod[W2-1:XLEN];
        if (r_f3 == 3'b000)
            w_result_fix = w_prod[XLEN-1:0];
    end
`endif

    // Datapath registers carry no reset; the FSM decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_special) begin
                r_acc <= {{XLEN{1'b0}}, w_spec_val};
            end else if (w_is_div) begin
                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                r_opb <= w_mag_b;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag_b};
                r_opb <= w_mag_a;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_step_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r   <= 1'b0;
`endif
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3    <= bus.funct3_i;
                        r_neg_q <= w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
                        r_neg_r <= w_neg_a;
`endif
                        r_cnt   <= '0;
                        // Special cases wait one cycle in DONE so done_o lands at t1.
                        r_pend  <= w_special;
                        r_state <= w_special ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.kill_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 6'd31) begin
                        r_state <= S_FIX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_FIX: begin
                    if (bus.kill_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_result_fix;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    if (bus.kill_i) begin
                        r_pend  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_pend) begin
                        r_pend   <= 1'b0;
                        r_result <= r_acc[XLEN-1:0];
                        r_done   <= 1'b1;
`ifndef MULDIV_DIV_EN
                        r_illegal <= 1'b1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready_o   = (r_state == S_IDLE);
    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.done_o    = r_done;
    assign bus.illegal_o = r_illegal;
    assign bus.result_o  = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_exp = 32'h0;
    logic seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after an edge with the DUT idle; returns just after the accept edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic k);
        bus.valid_i  = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.kill_i   = k;
        @(posedge clk);
        #1;
        bus.valid_i  = 1'b0;
        bus.kill_i   = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input logic ill, input logic k);
        int n;
        start_op(f3, a, b, k);
        check({tag, "_busy"}, {31'b0, bus.busy_o}, 32'd1);
        n = 0;
        while (!bus.done_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_res"}, bus.result_o, exp);
        check({tag, "_ill"}, {31'b0, bus.illegal_o}, {31'b0, ill});
        @(posedge clk);
        #1;
        check({tag, "_rdy"}, {30'b0, bus.done_o, bus.ready_o}, 32'd1);
        prev_exp = exp;
    endtask

    initial begin
        bus.valid_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = 32'h0;
        bus.rs2_i    = 32'h0;
        #12;
        check("rst_ready",   {31'b0, bus.ready_o},   32'd1);
        check("rst_busy",    {31'b0, bus.busy_o},    32'd0);
        check("rst_done",    {31'b0, bus.done_o},    32'd0);
        check("rst_illegal", {31'b0, bus.illegal_o}, 32'd0);
        check("rst_result",  bus.result_o,           32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_neg",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);
        run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0, 1'b0);
        run_op("mulhu_max",3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0, 1'b0);
        run_op("mul_kill_idle", 3'b000, 32'd3,   32'd4,        32'd12,       33, 1'b0, 1'b1);

`ifdef MULDIV_DIV_EN
        run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0, 1'b0);
        run_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0, 1'b0);
        run_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0, 1'b0);
        run_op("div_zero", 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0, 1'b0);
        run_op("remu_zero",3'b111, 32'd5,        32'd0,        32'd5,        1,  1'b0, 1'b0);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0, 1'b0);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  1'b0, 1'b0);
`else
        run_op("divu_ill", 3'b101, 32'd10,       32'd2,        32'h0,        1,  1'b1, 1'b0);
        run_op("rem_ill",  3'b110, 32'hFFFFFFF9, 32'd2,        32'h0,        1,  1'b1, 1'b0);
        run_op("mul_3x4",  3'b000, 32'd3,        32'd4,        32'd12,       33, 1'b0, 1'b0);
`endif

        // Abort a multiply mid-CALC; kill sampled at t11.
        start_op(3'b000, 32'h1234, 32'h5, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done_o;
        end
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        seen = seen | bus.done_o;
        check("kill_ready",  {31'b0, bus.ready_o}, 32'd1);
        check("kill_busy",   {31'b0, bus.busy_o},  32'd0);
        check("kill_nodone", {31'b0, seen},        32'd0);
        check("kill_result", bus.result_o,         prev_exp);
        run_op("after_kill", 3'b000, 32'h1234, 32'h5, 32'h5B04, 33, 1'b0, 1'b0);

        // Asynchronous reset mid-CALC.
        start_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ready",   {31'b0, bus.ready_o},   32'd1);
        check("arst_busy",    {31'b0, bus.busy_o},    32'd0);
        check("arst_done",    {31'b0, bus.done_o},    32'd0);
        check("arst_illegal", {31'b0, bus.illegal_o}, 32'd0);
        check("arst_result",  bus.result_o,           32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done_o;
        end
        #3;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done_o;
        end
        check("arst_nodone", {31'b0, seen},         32'd0);
        check("arst_ready2", {31'b0, bus.ready_o},  32'd1);
        run_op("post_rst", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations, placed beside the single-cycle ALU in the execute stage. It accepts one operation per handshake and runs it as a 32-step shift-add multiply or restoring divide over operand magnitudes. It then applies sign correction and returns the 32-bit result with a one-cycle `done_o` pulse. The pipeline holds execute while `busy_o` is high.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `valid_i`  in  1  request valid; sampled only when `ready_o`=1.
- `ready_o`  out  1  high only in IDLE.
- `funct3_i`  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i`, `rs2_i`  in  XLEN  operands, latched at accept.
- `kill_i`  in  1  synchronous abort from pipeline flush.
- `busy_o`  out  1  high in CALC, FIX and DONE.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid in that cycle.
- `result_o`  out  XLEN  result; held until the next accept.
- `illegal_o`  out  1  one-cycle pulse, with `done_o`, for a compiled-out op.

## Operation
- FSM states are IDLE, CALC, FIX and DONE. A 6-bit step counter runs from 0 to 31.
- Accept = `valid_i` & `ready_o` at a clock edge. The sequencer latches `funct3_i`, `|rs1_i|`, `|rs2_i|` and the result sign.
  - Operands are signed for MUL, MULH, DIV and REM.
  - For MULHSU, rs1 is signed and rs2 is unsigned.
- Multiply uses a 64-bit accumulator. Each CALC step adds the multiplicand when the multiplier LSB is 1, then shifts right one bit.
  - FIX negates the 64-bit product when the sign flag is set.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide uses restoring division on a 33-bit partial remainder. Each CALC step shifts left, subtracts the divisor, and restores when the result is negative. One quotient bit is produced per step.
  - FIX negates the quotient when the operand signs differ.
  - FIX negates the remainder when the dividend is negative.
- Special cases skip CALC and FIX: the accept edge goes straight to DONE.
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `rs1_i`.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- `kill_i`=1 in CALC, FIX or DONE forces IDLE at the next edge.
  - No `done_o` is produced.
  - `result_o` keeps its previous value.
- `kill_i` in IDLE is ignored. If `kill_i` and `valid_i` are both high in IDLE, the request is accepted.

## Timing
- Reset values: state IDLE, counter 0, `ready_o`=1, `busy_o`=0, `done_o`=0, `illegal_o`=0, `result_o`=0.
- Asserting `rst_n` mid-operation drops the operation immediately; no `done_o` is produced.
- Normal path:
  - Accept edge t0 leads to CALC.
  - Steps run at edges t1 through t32; t32 leads to FIX.
  - Edge t33 leads to DONE, so `done_o` is high from t33 to t34.
  - Edge t34 returns to IDLE.
- Special-case path: `done_o` is high from t1 to t2.
- Back-to-back operation: the next accept is possible at t35 for the normal path and at t3 for the special case.
- `ready_o` and `busy_o` are decoded from the registered state. `done_o`, `illegal_o` and `result_o` are registered outputs.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops are supported.
- `MULDIV_DIV_EN` undefined:
  - Divide datapath and restoring logic are removed.
  - Ops with `funct3_i[2]`=1 take the special path and give `done_o` and `illegal_o` at t1 with `result_o`=0.
  - Multiply ops are unchanged.

## Test plan
- Reset with `rst_n`=0 mid-CALC -> all outputs return to their reset values immediately; `done_o` never pulses; `ready_o`=1 after release.
- MUL 7 × 0xFFFFFFFD (−3) -> `done_o` at t33, `result_o`=0xFFFFFFEB; MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100/7 -> 14 at t33; REM 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFF; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF at t1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at t1; REM of the same -> 0.
- MUL started, `kill_i` pulsed at t10 -> IDLE at t11, no `done_o`, `result_o` unchanged; a new request at t11 completes normally.
- Build without `MULDIV_DIV_EN`, DIVU 10/2 -> `done_o` and `illegal_o` at t1, `result_o`=0; MUL 3×4 -> 12 at t33.
